pipe_stage_fifo: RTL
====================

PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 Parameter WIDTH, default 128, payload bits per entry (decode-stage bundle width); legal range 1..512.
REQ-002 Parameter DEPTH, default 2, buffer entries; legal values 1, 2, 4, 8.
REQ-003 Parameter CNTW, default 16, statistics counter width.
REQ-004 stg_clk  in  1  single stage clock, all state on rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 stg_x  in  1  flush/kill; discards all buffered entries.
REQ-007 in_valid  in  1  upstream entry offered.
REQ-008 in_ready  out  1  block can accept an entry this cycle.
REQ-009 in_data  in  WIDTH  upstream payload.
REQ-010 out_valid  out  1  head entry present.
REQ-011 out_ready  in  1  downstream accepts head entry.
REQ-012 out_data  out  WIDTH  head entry payload.
REQ-013 occupancy  out  $clog2(DEPTH+1)  current entry count.
REQ-014 stall_cnt  out  CNTW  cycles with out_valid=1 and out_ready=0 (REQ-027 only).
REQ-015 occ_hwm  out  $clog2(DEPTH+1)  highest occupancy seen (REQ-027 only).

Function
REQ-016 Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated in the same cycle.
REQ-017 in_ready SHALL be 1 iff occupancy < DEPTH, with no combinational path from out_ready (no push into a full buffer even on a simultaneous pop).
REQ-018 out_valid SHALL be 1 iff occupancy != 0; out_data SHALL be the oldest entry, and all-zeros when occupancy = 0.
REQ-019 Latency: an entry pushed at edge N SHALL be visible on out_data after edge N; no same-cycle bypass from in_data.
REQ-020 Ordering SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-021 Push and pop together SHALL leave occupancy unchanged and advance both pointers.
REQ-022 stg_x=1 SHALL zero occupancy and both pointers at the next edge, discard any same-cycle push, and ignore any same-cycle pop; stg_x takes priority over push and pop.
REQ-023 out_valid/out_data SHALL be stable while out_valid=1 and out_ready=0, unless stg_x=1.

Reset
REQ-024 reset_n=0 at an edge SHALL set occupancy=0, both pointers=0, out_valid=0, out_data=0, in_ready=1, stall_cnt=0, occ_hwm=0; reset overrides stg_x, push and pop.
REQ-025 Storage array contents need not be reset; REQ-018 masks them.
REQ-026 Reset asserted mid-transfer SHALL drop all entries without emitting a partial or duplicate entry afterwards.

Configuration
REQ-027 Macro PIPE_STAGE_STATS_EN: when defined, stall_cnt (increments by 1 per stalled cycle, saturates at all-ones) and occ_hwm (max occupancy since reset) exist; stg_x does not clear them. When undefined, both ports and their logic are absent and the remaining behaviour is unchanged.

Structure
REQ-028 Shared package pipe_pkg SHALL hold the WIDTH/DEPTH/CNTW defaults, the pointer-width function, and the decode-stage payload field offsets (pc, rs1, rs2, rd, funct3, funct7, imm, opcode, control flags).
REQ-029 Storage SHALL be a sub-module pipe_stage_ram (DEPTH x WIDTH, one write port, one async read port); pointers, counters and handshake stay in pipe_stage_fifo.

Verification
REQ-030 DEPTH=2: push 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA held; third in_valid ignored.
REQ-031 Full buffer, in_valid=1, out_ready=1 for one cycle -> pop 0xA only, occupancy 1, out_data=0xB; push accepted next cycle.
REQ-032 Stream 16 sequential values with random out_ready -> output order 0..15, no loss/dup, pointer wrap exercised.
REQ-033 Occupancy 2, stg_x=1 with in_valid=1 -> next cycle occupancy 0, out_valid=0, out_data=0; pushed value never emerges.
REQ-034 reset_n=0 for one cycle while occupancy=1 -> all outputs at REQ-024 values; reset_n=1 with stg_x=1 -> still empty.
REQ-035 PIPE_STAGE_STATS_EN, CNTW=4: 20 stalled cycles -> stall_cnt=15; occ_hwm=2 retained after stg_x.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the decode-stage pipeline buffer.
//                Holds parameter defaults, the pointer-width helper and the
//                bit offsets of the decode-stage payload fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Parameter defaults
    localparam int PIPE_WIDTH_DEF = 128;
    localparam int PIPE_DEPTH_DEF = 2;
    localparam int PIPE_CNTW_DEF  = 16;

    // Decode-stage payload layout (LSB offsets and widths, 128 bits total)
    localparam int PL_PC_OFS      = 0;
    localparam int PL_PC_W        = 32;
    localparam int PL_RS1_OFS     = 32;
    localparam int PL_RS1_W       = 5;
    localparam int PL_RS2_OFS     = 37;
    localparam int PL_RS2_W       = 5;
    localparam int PL_RD_OFS      = 42;
    localparam int PL_RD_W        = 5;
    localparam int PL_FUNCT3_OFS  = 47;
    localparam int PL_FUNCT3_W    = 3;
    localparam int PL_FUNCT7_OFS  = 50;
    localparam int PL_FUNCT7_W    = 7;
    localparam int PL_IMM_OFS     = 57;
    localparam int PL_IMM_W       = 32;
    localparam int PL_OPCODE_OFS  = 89;
    localparam int PL_OPCODE_W    = 7;
    localparam int PL_CTRL_OFS    = 96;
    localparam int PL_CTRL_W      = 32;

    // Pointer width for a buffer of 'depth' entries; a single-entry buffer
    // still carries a 1-bit pointer so that no zero-width vector appears.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_ram.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_ram
//  Description : DEPTH x WIDTH storage for the pipeline buffer. One
//                synchronous write port, one asynchronous read port.
//                Contents are deliberately not reset; the parent masks
//                stale data whenever the buffer is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_ram
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF,
    parameter int DEPTH = PIPE_DEPTH_DEF,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic             stg_clk,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry on an accepted push
    always_ff @(posedge stg_clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Head entry is read combinationally so it is visible right after the write edge
    assign rd_data = r_mem[rd_addr];

endmodule : pipe_stage_ram
`default_nettype wire

// File: rtl/pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_fifo
//  Description : Valid/ready decode-stage buffer of DEPTH entries with flush
//                (stg_x), strict FIFO ordering and no combinational path
//                from out_ready to in_ready. Optional statistics (stall
//                cycle counter, occupancy high-water mark) are built when
//                the macro PIPE_STAGE_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_fifo
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF,
    parameter int DEPTH = PIPE_DEPTH_DEF,
    parameter int CNTW  = PIPE_CNTW_DEF
) (
    input  logic                         stg_clk,
    input  logic                         reset_n,
    input  logic                         stg_x,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
`ifdef PIPE_STAGE_STATS_EN
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNTW-1:0]              stall_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   occ_hwm
`else
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    localparam logic [OW-1:0] C_FULL = OW'(DEPTH);
    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);
    localparam logic [OW-1:0] C_ONE  = OW'(1);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [OW-1:0]    r_occ;

    logic             w_push;
    logic             w_pop;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [PW-1:0]    w_wr_ptr_inc;
    logic [PW-1:0]    w_rd_ptr_inc;
    logic [OW-1:0]    w_occ_nxt;
    logic [WIDTH-1:0] w_rd_data;

    // Ready depends only on registered occupancy, so a full buffer refuses a
    // push even when a pop happens in the same cycle.
    assign w_in_ready  = (r_occ < C_FULL);
    assign w_out_valid = (r_occ != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // Pointer increments wrap at DEPTH-1 so non-power-of-two wrap stays explicit
    always_comb begin
        w_wr_ptr_inc = (r_wr_ptr == C_LAST) ? '0 : (r_wr_ptr + PW'(1));
        w_rd_ptr_inc = (r_rd_ptr == C_LAST) ? '0 : (r_rd_ptr + PW'(1));
    end

    // Next occupancy: flush empties, simultaneous push/pop leaves it unchanged
    always_comb begin
        w_occ_nxt = r_occ;
        if (stg_x) begin
            w_occ_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_occ_nxt = r_occ + C_ONE;
                2'b01:   w_occ_nxt = r_occ - C_ONE;
                default: w_occ_nxt = r_occ;
            endcase
        end
    end

    // Pointer and occupancy registers; reset overrides flush, flush overrides traffic
    always_ff @(posedge stg_clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (stg_x) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= w_wr_ptr_inc;
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
            end
        end
    end

    pipe_stage_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .stg_clk (stg_clk),
        .wr_en   (w_push & ~stg_x & reset_n),
        .wr_addr (r_wr_ptr),
        .wr_data (in_data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // Stale storage is masked to zero whenever the buffer is empty
    assign out_data  = w_out_valid ? w_rd_data : '0;
    assign out_valid = w_out_valid;
    assign in_ready  = w_in_ready;
    assign occupancy = r_occ;

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNTW-1:0] C_CNT_MAX = '1;

    logic [CNTW-1:0] r_stall_cnt;
    logic [OW-1:0]   r_occ_hwm;

    // Saturating stall counter and high-water mark; flush leaves both intact
    always_ff @(posedge stg_clk) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_occ_hwm   <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            // Tracking the next value keeps the mark in step with occupancy
            if (w_occ_nxt > r_occ_hwm) begin
                r_occ_hwm <= w_occ_nxt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign occ_hwm   = r_occ_hwm;
`endif

endmodule : pipe_stage_fifo
`default_nettype wire
